stall_ctrl: RTL

STALL_CTRL -- requirements
Module: stall_ctrl

---
 rtl/stall_ctrl_pkg.sv | 20 ++
 rtl/div_timer.sv | 41 ++++
 rtl/stall_ctrl.sv | 92 +++++++++
 3 files changed

// File: rtl/stall_ctrl_pkg.sv
// Shared CPU pipeline-control definitions: MEM-stage exception codes,
// per-register stall patterns and the stall controller state encoding.
package stall_ctrl_pkg;

   localparam logic [4:0] EXC_NONE = 5'h10;
   localparam logic [4:0] EXC_ERET = 5'h11;

   localparam logic [3:0] STALL_NONE   = 4'b0000;
   localparam logic [3:0] STALL_BUBBLE = 4'b0111;
   localparam logic [3:0] STALL_ALL    = 4'b1111;

   localparam int CNT_W = 6;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DIV   = 2'd1,
      ST_FLUSH = 2'd2
   } state_e;

endpackage

// File: rtl/div_timer.sv
// Divide-occupancy down-counter: loads on a divide start, counts down while
// enabled and flags when it has reached zero.
module div_timer
   import stall_ctrl_pkg::*;
#(
   parameter int unsigned LOAD_VAL = 33
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load_i,
   input  logic count_i,
   input  logic clear_i,
   output logic zero_o
);

   localparam logic [CNT_W-1:0] LOAD = CNT_W'(LOAD_VAL);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (load_i) begin
         cnt_d = LOAD;
      end else if (count_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/stall_ctrl.sv
// Pipeline stall/flush controller: holds the pipeline for load-use hazards,
// data-memory waits and multi-cycle divides, and flushes on exception/ERET.
module stall_ctrl
   import stall_ctrl_pkg::*;
#(
   parameter int unsigned DIV_CYCLES = 34,
   parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stallreq_id,
   input  logic        div_start,
   input  logic        dmem_wait,
   input  logic [4:0]  mem_exccode,
   input  logic [31:0] cp0_epc,
   output logic [3:0]  stall,
   output logic        flush,
   output logic [31:0] flush_pc,
   output logic        div_busy,
   output logic        div_done,
   output state_e      dbg_state_o
);

   if (DIV_CYCLES < 2 || DIV_CYCLES > 63) begin : g_bad_div_cycles
      $error("stall_ctrl: DIV_CYCLES out of range 2..63");
   end

   state_e      state_q;
   logic        flush_q;
   logic [31:0] flush_pc_q;
   logic        exc_pend;
   logic        div_go;
   logic        timer_zero;

   // FLUSH ignores every input, so nothing can be pending while in it.
   assign exc_pend = (state_q != ST_FLUSH) && (mem_exccode != EXC_NONE);
   assign div_go   = (state_q == ST_IDLE) && div_start && !exc_pend;

   div_timer #(
      .LOAD_VAL (DIV_CYCLES - 1)
   ) u_div_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (div_go),
      .count_i (state_q == ST_DIV),
      .clear_i (exc_pend),
      .zero_o  (timer_zero)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         flush_q    <= 1'b0;
         flush_pc_q <= '0;
      end else begin
         flush_q    <= 1'b0;
         flush_pc_q <= '0;
         if (exc_pend) begin
            state_q    <= ST_FLUSH;
            flush_q    <= 1'b1;
            flush_pc_q <= (mem_exccode == EXC_ERET) ? cp0_epc : EXC_VECTOR;
         end else begin
            case (state_q)
               ST_IDLE:  if (div_start) state_q <= ST_DIV;
               ST_DIV:   if (timer_zero) state_q <= ST_IDLE;
               ST_FLUSH: state_q <= ST_IDLE;
               default:  state_q <= ST_IDLE;
            endcase
         end
      end
   end

   always_comb begin
      stall = STALL_NONE;
      if (!rst_n || state_q == ST_FLUSH) begin
         stall = STALL_NONE;
      end else if (exc_pend || dmem_wait) begin
         stall = STALL_ALL;
      end else if ((state_q == ST_DIV && !timer_zero) || div_go) begin
         stall = STALL_ALL;
      end else if (stallreq_id) begin
         stall = STALL_BUBBLE;
      end
   end

   assign flush       = flush_q;
   assign flush_pc    = flush_pc_q;
   assign div_busy    = (state_q == ST_DIV);
   assign div_done    = (state_q == ST_DIV) && timer_zero && !exc_pend;
   assign dbg_state_o = state_q;

endmodule
